// File: rtl/idecode_q.sv
// Instruction decode stage with a small FIFO of decoded entries toward EX.
// Instruction word: opc[WORD-1 -: W_OPC], immf, rd[W_RD], rs[W_RD], imm[remaining low bits].
module idecode_q #(
  parameter int WORD  = 32,
  parameter int ADDR  = 32,
  parameter int W_RD  = 3,
  parameter int DEPTH = 2,
  localparam int W_OPC  = 6,
  localparam int W_DOPC = 4,
  localparam int W_CC   = 2,
  localparam int W_CNT  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_i,
  input  logic [WORD-1:0]   inst_i,
  input  logic [ADDR-1:0]   origaddr_i,
  output logic              stall_o,
  output logic              v_o,
  input  logic              stall_i,
  output logic [WORD-1:0]   src_o,
  output logic [WORD-1:0]   dest_o,
  output logic              wb_o,
  output logic [W_RD-1:0]   wb_rd_name_o,
  output logic [W_DOPC-1:0] dopc_o,
  output logic [W_OPC-1:0]  opc_o,
  output logic [W_CC-1:0]   cc_o,
  output logic [ADDR-1:0]   origaddr_o,
  output logic [W_CNT-1:0]  count_o,
  output logic              rd_reserve_o,
  output logic [W_RD-1:0]   rd_name_o,
  output logic [W_RD-1:0]   rs_name_o,
  input  logic [WORD-1:0]   rd_data_i,
  input  logic [WORD-1:0]   rs_data_i,
  input  logic              rd_reserved_i,
  input  logic              rs_reserved_i
);

  localparam int W_IMM = WORD - W_OPC - 1 - 2 * W_RD;
  localparam int P_IMMF = WORD - W_OPC - 1;
  localparam int P_RD   = P_IMMF - 1;
  localparam int P_RS   = P_RD - W_RD;
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [W_OPC-1:0] {
    OP_NOP = 6'd0,
    OP_ADD = 6'd1,
    OP_SUB = 6'd2,
    OP_AND = 6'd3,
    OP_OR  = 6'd4,
    OP_XOR = 6'd5,
    OP_SHL = 6'd6,
    OP_SHR = 6'd7,
    OP_LD  = 6'd8,
    OP_ST  = 6'd9,
    OP_BR  = 6'd10,
    OP_MOV = 6'd11
  } opc_e;

  typedef enum logic [W_DOPC-1:0] {
    D_NOP = 4'd0,
    D_ADD = 4'd1,
    D_SUB = 4'd2,
    D_AND = 4'd3,
    D_OR  = 4'd4,
    D_XOR = 4'd5,
    D_SHL = 4'd6,
    D_SHR = 4'd7,
    D_LD  = 4'd8,
    D_ST  = 4'd9,
    D_BR  = 4'd10,
    D_MOV = 4'd11,
    D_ILL = 4'd15
  } dopc_e;

  typedef struct packed {
    logic [WORD-1:0]   src;
    logic [WORD-1:0]   dest;
    logic              wb;
    logic [W_RD-1:0]   rd;
    logic [W_DOPC-1:0] dopc;
    logic [W_OPC-1:0]  opc;
    logic [W_CC-1:0]   cc;
    logic [ADDR-1:0]   addr;
  } entry_t;

  function automatic logic wb_required(input logic [W_OPC-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SHL, OP_SHR, OP_LD, OP_MOV: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic [W_DOPC-1:0] decode_ope(input logic [W_OPC-1:0] op);
    case (op)
      OP_NOP:  return D_NOP;
      OP_ADD:  return D_ADD;
      OP_SUB:  return D_SUB;
      OP_AND:  return D_AND;
      OP_OR:   return D_OR;
      OP_XOR:  return D_XOR;
      OP_SHL:  return D_SHL;
      OP_SHR:  return D_SHR;
      OP_LD:   return D_LD;
      OP_ST:   return D_ST;
      OP_BR:   return D_BR;
      OP_MOV:  return D_MOV;
      default: return D_ILL;
    endcase
  endfunction

  // Logical ops take an unsigned immediate; everything else sign-extends.
  function automatic logic [WORD-1:0] expand_imm(input logic [W_OPC-1:0] op,
                                                 input logic [W_IMM-1:0] imm);
    case (op)
      OP_AND, OP_OR, OP_XOR: return {{(WORD - W_IMM){1'b0}}, imm};
      default:               return {{(WORD - W_IMM){imm[W_IMM-1]}}, imm};
    endcase
  endfunction

  logic [W_OPC-1:0] f_opc;
  logic             f_immf;
  logic [W_RD-1:0]  f_rd;
  logic [W_RD-1:0]  f_rs;
  logic [W_IMM-1:0] f_imm;

  assign f_opc  = inst_i[WORD-1 -: W_OPC];
  assign f_immf = inst_i[P_IMMF];
  assign f_rd   = inst_i[P_RD -: W_RD];
  assign f_rs   = inst_i[P_RS -: W_RD];
  assign f_imm  = inst_i[W_IMM-1:0];

  assign rd_name_o = f_rd;
  assign rs_name_o = f_rs;

  entry_t          mem [DEPTH];
  entry_t          wr_ent;
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [W_CNT-1:0] count;
  logic            hazard;
  logic            full;
  logic            push;
  logic            pop;

  assign hazard = rd_reserved_i | (~f_immf & rs_reserved_i);
  assign v_o    = (count != '0);
  assign full   = (count == W_CNT'(DEPTH));
  assign pop    = v_o & ~stall_i;
  // Gating with rst keeps reservations and storage writes quiet during reset.
  assign push   = rst & v_i & ~hazard & (~full | pop);

  assign stall_o      = v_i & ~push;
  assign rd_reserve_o = push & wb_required(f_opc);
  assign count_o      = count;

  always_comb begin
    wr_ent      = '0;
    wr_ent.src  = f_immf ? expand_imm(f_opc, f_imm) : rs_data_i;
    wr_ent.dest = rd_data_i;
    wr_ent.wb   = wb_required(f_opc);
    wr_ent.rd   = f_rd;
    wr_ent.dopc = decode_ope(f_opc);
    wr_ent.opc  = f_opc;
    wr_ent.cc   = f_rd[W_CC-1:0];
    wr_ent.addr = origaddr_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (DEPTH == 1) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (DEPTH == 1) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head         = mem[rd_ptr];
  assign src_o        = head.src;
  assign dest_o       = head.dest;
  assign wb_o         = head.wb;
  assign wb_rd_name_o = head.rd;
  assign dopc_o       = head.dopc;
  assign opc_o        = head.opc;
  assign cc_o         = head.cc;
  assign origaddr_o   = head.addr;

endmodule

// File: tb/tb_idecode_q.sv
// Directed bench for idecode_q: default DEPTH=2 instance plus a DEPTH=1 instance.
module tb_idecode_q;

  localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_OR = 6'd4, OP_XOR = 6'd5,
                         OP_SHR = 6'd7, OP_LD = 6'd8, OP_ST = 6'd9, OP_BR = 6'd10;

  logic        clk, rst, v_i, stall_i, rd_reserved_i, rs_reserved_i;
  logic [31:0] inst_i, origaddr_i, rd_data_i, rs_data_i;

  logic        stall_o, v_o, wb_o, rd_reserve_o;
  logic [31:0] src_o, dest_o, origaddr_o;
  logic [2:0]  wb_rd_name_o, rd_name_o, rs_name_o;
  logic [3:0]  dopc_o;
  logic [5:0]  opc_o;
  logic [1:0]  cc_o;
  logic [1:0]  count_o;

  logic        stall_o_1, v_o_1, wb_o_1, rd_reserve_o_1;
  logic [31:0] src_o_1, dest_o_1, origaddr_o_1;
  logic [2:0]  wb_rd_name_o_1, rd_name_o_1, rs_name_o_1;
  logic [3:0]  dopc_o_1;
  logic [5:0]  opc_o_1;
  logic [1:0]  cc_o_1;
  logic        count_o_1;

  int total = 0;
  int bad = 0;

  idecode_q #(.WORD(32), .ADDR(32), .W_RD(3), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .origaddr_i(origaddr_i),
    .stall_o(stall_o), .v_o(v_o), .stall_i(stall_i), .src_o(src_o), .dest_o(dest_o),
    .wb_o(wb_o), .wb_rd_name_o(wb_rd_name_o), .dopc_o(dopc_o), .opc_o(opc_o), .cc_o(cc_o),
    .origaddr_o(origaddr_o), .count_o(count_o), .rd_reserve_o(rd_reserve_o),
    .rd_name_o(rd_name_o), .rs_name_o(rs_name_o), .rd_data_i(rd_data_i), .rs_data_i(rs_data_i),
    .rd_reserved_i(rd_reserved_i), .rs_reserved_i(rs_reserved_i)
  );

  idecode_q #(.WORD(32), .ADDR(32), .W_RD(3), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .v_i(v_i), .inst_i(inst_i), .origaddr_i(origaddr_i),
    .stall_o(stall_o_1), .v_o(v_o_1), .stall_i(stall_i), .src_o(src_o_1), .dest_o(dest_o_1),
    .wb_o(wb_o_1), .wb_rd_name_o(wb_rd_name_o_1), .dopc_o(dopc_o_1), .opc_o(opc_o_1), .cc_o(cc_o_1),
    .origaddr_o(origaddr_o_1), .count_o(count_o_1), .rd_reserve_o(rd_reserve_o_1),
    .rd_name_o(rd_name_o_1), .rs_name_o(rs_name_o_1), .rd_data_i(rd_data_i), .rs_data_i(rs_data_i),
    .rd_reserved_i(rd_reserved_i), .rs_reserved_i(rs_reserved_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic immf,
                                     input logic [2:0] rd, input logic [2:0] rs,
                                     input logic [18:0] imm);
    return {op, immf, rd, rs, imm};
  endfunction

  task automatic test_reset();
    rst = 1'b0; v_i = 1'b1; stall_i = 1'b0; inst_i = mk(OP_ADD, 1'b1, 3'd2, 3'd0, 19'd5);
    @(negedge clk); #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL reset_v_o: got %0h want 0", v_o); end
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
    total++; if (rd_reserve_o !== 1'b0) begin bad++; $display("FAIL reset_rd_reserve: got %0h want 0", rd_reserve_o); end
    total++; if (src_o !== 32'h0) begin bad++; $display("FAIL reset_src: got %h want 0", src_o); end
    @(negedge clk); rst = 1'b1; v_i = 1'b0; #1;
  endtask

  task automatic test_imm_add();
    @(negedge clk);
    v_i = 1'b1; stall_i = 1'b1; inst_i = mk(OP_ADD, 1'b1, 3'd2, 3'd0, 19'd5);
    origaddr_i = 32'h1000; rd_data_i = 32'hDDDD0002; #1;
    total++; if (rd_reserve_o !== 1'b1) begin bad++; $display("FAIL add_rd_reserve: got %0h want 1", rd_reserve_o); end
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL add_stall: got %0h want 0", stall_o); end
    total++; if (rd_name_o !== 3'd2) begin bad++; $display("FAIL add_rd_name: got %0d want 2", rd_name_o); end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (v_o !== 1'b1) begin bad++; $display("FAIL add_v_o: got %0h want 1", v_o); end
    total++; if (src_o !== 32'd5) begin bad++; $display("FAIL add_src: got %h want 5", src_o); end
    total++; if (wb_rd_name_o !== 3'd2) begin bad++; $display("FAIL add_wb_rd: got %0d want 2", wb_rd_name_o); end
    total++; if (count_o !== 2'd1) begin bad++; $display("FAIL add_count: got %0d want 1", count_o); end
    total++; if (dest_o !== 32'hDDDD0002) begin bad++; $display("FAIL add_dest: got %h want DDDD0002", dest_o); end
    total++; if (dopc_o !== 4'd1 || wb_o !== 1'b1 || cc_o !== 2'd2 || opc_o !== OP_ADD)
      begin bad++; $display("FAIL add_fields: got dopc=%0d wb=%0d cc=%0d opc=%0d want 1 1 2 1", dopc_o, wb_o, cc_o, opc_o); end
    total++; if (origaddr_o !== 32'h1000) begin bad++; $display("FAIL add_addr: got %h want 1000", origaddr_o); end
    stall_i = 1'b0;
    @(negedge clk); #1;
    total++; if (v_o !== 1'b0 || count_o !== 2'd0) begin bad++; $display("FAIL add_drain: got v=%0d cnt=%0d want 0 0", v_o, count_o); end
  endtask

  task automatic test_fill();
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v_i = 1'b1; inst_i = mk(OP_SUB, 1'b1, 3'(3 + k), 3'd1, 19'h7FFFF);
      origaddr_i = 32'h2000 + 32'(4 * k); #1;
      total++; if (count_o !== 2'(k)) begin bad++; $display("FAIL fill_count%0d: got %0d want %0d", k, count_o, k); end
      total++; if (stall_o !== (k == 2)) begin bad++; $display("FAIL fill_stall%0d: got %0d want %0d", k, stall_o, k == 2); end
      total++; if (rd_reserve_o !== (k < 2)) begin bad++; $display("FAIL fill_resv%0d: got %0d want %0d", k, rd_reserve_o, k < 2); end
    end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (count_o !== 2'd2) begin bad++; $display("FAIL fill_final_count: got %0d want 2", count_o); end
    total++; if (origaddr_o !== 32'h2000 || src_o !== 32'hFFFFFFFF || wb_rd_name_o !== 3'd3)
      begin bad++; $display("FAIL fill_head: got %h %h %0d want 2000 FFFFFFFF 3", origaddr_o, src_o, wb_rd_name_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    exp_q.push_back(32'h2000);
    exp_q.push_back(32'h2004);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      stall_i = 1'b0; v_i = 1'b1; inst_i = mk(OP_ADD, 1'b1, 3'(k), 3'd0, 19'(k));
      origaddr_i = 32'h3000 + 32'(4 * k); #1;
      total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL b2b_stall%0d: got %0d want 0", k, stall_o); end
      total++; if (count_o !== 2'd2) begin bad++; $display("FAIL b2b_count%0d: got %0d want 2", k, count_o); end
      total++; if (origaddr_o !== exp_q[0]) begin bad++; $display("FAIL b2b_order%0d: got %h want %h", k, origaddr_o, exp_q[0]); end
      void'(exp_q.pop_front());
      exp_q.push_back(32'h3000 + 32'(4 * k));
    end
    for (int j = 0; j < 2; j++) begin
      @(negedge clk); v_i = 1'b0; #1;
      total++; if (v_o !== 1'b1 || origaddr_o !== exp_q[0]) begin bad++; $display("FAIL b2b_drain%0d: got v=%0d %h want 1 %h", j, v_o, origaddr_o, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    @(negedge clk); #1;
    total++; if (v_o !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %0d want 0", v_o); end
  endtask

  task automatic test_hazard();
    @(negedge clk);
    stall_i = 1'b0; v_i = 1'b1; inst_i = mk(OP_ADD, 1'b0, 3'd1, 3'd3, 19'd0); rs_reserved_i = 1'b1; #1;
    total++; if (stall_o !== 1'b1 || rd_reserve_o !== 1'b0) begin bad++; $display("FAIL haz_rs: got stall=%0d resv=%0d want 1 0", stall_o, rd_reserve_o); end
    @(negedge clk);
    inst_i = mk(OP_ADD, 1'b1, 3'd1, 3'd3, 19'd7); origaddr_i = 32'h4000; #1;
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL haz_nopush: got %0d want 0", count_o); end
    total++; if (stall_o !== 1'b0 || rd_reserve_o !== 1'b1) begin bad++; $display("FAIL haz_immf: got stall=%0d resv=%0d want 0 1", stall_o, rd_reserve_o); end
    @(negedge clk); v_i = 1'b0; rs_reserved_i = 1'b0; #1;
    total++; if (v_o !== 1'b1 || src_o !== 32'd7 || origaddr_o !== 32'h4000) begin bad++; $display("FAIL haz_head: got v=%0d %h %h want 1 7 4000", v_o, src_o, origaddr_o); end
    @(negedge clk);
    v_i = 1'b1; inst_i = mk(OP_SUB, 1'b1, 3'd5, 3'd0, 19'd1); rd_reserved_i = 1'b1; #1;
    total++; if (stall_o !== 1'b1) begin bad++; $display("FAIL haz_rd: got %0d want 1", stall_o); end
    @(negedge clk);
    inst_i = mk(OP_SUB, 1'b0, 3'd5, 3'd2, 19'd0); rd_reserved_i = 1'b0; rs_data_i = 32'hCAFE0001; #1;
    total++; if (stall_o !== 1'b0 || v_o !== 1'b0) begin bad++; $display("FAIL haz_clear: got stall=%0d v=%0d want 0 0", stall_o, v_o); end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (v_o !== 1'b1 || src_o !== 32'hCAFE0001) begin bad++; $display("FAIL haz_rsdata: got v=%0d %h want 1 CAFE0001", v_o, src_o); end
  endtask

  task automatic test_decode();
    logic [31:0] t_inst [6];
    logic [31:0] t_src  [6];
    logic [3:0]  t_dopc [6];
    logic        t_wb   [6];
    logic [1:0]  t_cc   [6];
    t_inst[0] = mk(OP_ST,  1'b1, 3'd6, 3'd1, 19'h7FFF0); t_src[0] = 32'hFFFFFFF0; t_dopc[0] = 4'd9;  t_wb[0] = 1'b0; t_cc[0] = 2'd2;
    t_inst[1] = mk(OP_XOR, 1'b1, 3'd1, 3'd0, 19'h40000); t_src[1] = 32'h00040000; t_dopc[1] = 4'd5;  t_wb[1] = 1'b1; t_cc[1] = 2'd1;
    t_inst[2] = mk(6'd63,  1'b1, 3'd7, 3'd0, 19'h00010); t_src[2] = 32'h00000010; t_dopc[2] = 4'd15; t_wb[2] = 1'b0; t_cc[2] = 2'd3;
    t_inst[3] = mk(OP_BR,  1'b1, 3'd4, 3'd0, 19'h7FFFC); t_src[3] = 32'hFFFFFFFC; t_dopc[3] = 4'd10; t_wb[3] = 1'b0; t_cc[3] = 2'd0;
    t_inst[4] = mk(OP_LD,  1'b0, 3'd3, 3'd2, 19'h0);     t_src[4] = 32'h12345678; t_dopc[4] = 4'd8;  t_wb[4] = 1'b1; t_cc[4] = 2'd3;
    t_inst[5] = mk(OP_SHR, 1'b1, 3'd2, 3'd0, 19'h40003); t_src[5] = 32'hFFFC0003; t_dopc[5] = 4'd7;  t_wb[5] = 1'b1; t_cc[5] = 2'd2;
    rs_data_i = 32'h12345678; stall_i = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      v_i = (k < 6);
      if (k < 6) inst_i = t_inst[k];
      #1;
      if (k < 6) begin
        total++; if (rd_reserve_o !== t_wb[k]) begin bad++; $display("FAIL dec_resv%0d: got %0d want %0d", k, rd_reserve_o, t_wb[k]); end
      end
      if (k > 0) begin
        total++; if (src_o !== t_src[k-1]) begin bad++; $display("FAIL dec_src%0d: got %h want %h", k - 1, src_o, t_src[k-1]); end
        total++; if (dopc_o !== t_dopc[k-1] || wb_o !== t_wb[k-1] || cc_o !== t_cc[k-1])
          begin bad++; $display("FAIL dec_fields%0d: got %0d %0d %0d want %0d %0d %0d", k - 1, dopc_o, wb_o, cc_o, t_dopc[k-1], t_wb[k-1], t_cc[k-1]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    stall_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      v_i = 1'b1; inst_i = mk(OP_ADD, 1'b1, 3'(k + 1), 3'd0, 19'd1); origaddr_i = 32'h5000 + 32'(4 * k);
    end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (count_o !== 2'd2) begin bad++; $display("FAIL rmid_pre: got %0d want 2", count_o); end
    #1 rst = 1'b0; #1;
    total++; if (v_o !== 1'b0 || count_o !== 2'd0) begin bad++; $display("FAIL rmid_async: got v=%0d cnt=%0d want 0 0", v_o, count_o); end
    @(negedge clk);
    rst = 1'b1; v_i = 1'b1; inst_i = mk(OP_OR, 1'b1, 3'd6, 3'd0, 19'h00ABC); origaddr_i = 32'h6000; #1;
    total++; if (count_o !== 2'd0) begin bad++; $display("FAIL rmid_hold: got %0d want 0", count_o); end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (v_o !== 1'b1 || count_o !== 2'd1 || origaddr_o !== 32'h6000 || src_o !== 32'h00000ABC)
      begin bad++; $display("FAIL rmid_first: got v=%0d cnt=%0d %h %h want 1 1 6000 ABC", v_o, count_o, origaddr_o, src_o); end
    stall_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_a[$];
    logic [2:0]  exp_r[$];
    logic        exp_stall;
    int sent = 0;
    for (int cyc = 0; cyc < 100 && (sent < 10 || exp_a.size() > 0); cyc++) begin
      @(negedge clk);
      stall_i = cyc[0];
      v_i = (sent < 10);
      inst_i = mk(OP_ADD, 1'b1, 3'(sent), 3'd0, 19'(sent));
      origaddr_i = 32'h7000 + 32'(4 * sent); #1;
      exp_stall = v_i && (exp_a.size() == 2) && stall_i;
      total++; if (count_o !== 2'(exp_a.size())) begin bad++; $display("FAIL wrap_count%0d: got %0d want %0d", cyc, count_o, exp_a.size()); end
      total++; if (stall_o !== exp_stall) begin bad++; $display("FAIL wrap_stall%0d: got %0d want %0d", cyc, stall_o, exp_stall); end
      if (exp_a.size() > 0 && !stall_i) begin
        total++; if (origaddr_o !== exp_a[0] || wb_rd_name_o !== exp_r[0])
          begin bad++; $display("FAIL wrap_order%0d: got %h %0d want %h %0d", cyc, origaddr_o, wb_rd_name_o, exp_a[0], exp_r[0]); end
        void'(exp_a.pop_front());
        void'(exp_r.pop_front());
      end
      if (v_i && !exp_stall) begin
        exp_a.push_back(32'h7000 + 32'(4 * sent));
        exp_r.push_back(3'(sent));
        sent++;
      end
    end
    total++; if (sent != 10 || exp_a.size() != 0) begin bad++; $display("FAIL wrap_timeout: got sent=%0d left=%0d want 10 0", sent, exp_a.size()); end
    v_i = 1'b0;
  endtask

  task automatic test_depth1();
    @(negedge clk); rst = 1'b0; v_i = 1'b0; #1;
    @(negedge clk);
    rst = 1'b1; stall_i = 1'b1; v_i = 1'b1; inst_i = mk(OP_ADD, 1'b1, 3'd1, 3'd0, 19'd1); origaddr_i = 32'h8000; #1;
    total++; if (stall_o_1 !== 1'b0) begin bad++; $display("FAIL d1_first: got %0d want 0", stall_o_1); end
    @(negedge clk);
    inst_i = mk(OP_ADD, 1'b1, 3'd2, 3'd0, 19'd2); origaddr_i = 32'h8004; #1;
    total++; if (count_o_1 !== 1'b1 || stall_o_1 !== 1'b1) begin bad++; $display("FAIL d1_full: got cnt=%0d stall=%0d want 1 1", count_o_1, stall_o_1); end
    @(negedge clk); stall_i = 1'b0; #1;
    total++; if (stall_o_1 !== 1'b0 || origaddr_o_1 !== 32'h8000) begin bad++; $display("FAIL d1_pass: got stall=%0d %h want 0 8000", stall_o_1, origaddr_o_1); end
    @(negedge clk); v_i = 1'b0; #1;
    total++; if (origaddr_o_1 !== 32'h8004 || count_o_1 !== 1'b1 || src_o_1 !== 32'd2)
      begin bad++; $display("FAIL d1_next: got %h cnt=%0d %h want 8004 1 2", origaddr_o_1, count_o_1, src_o_1); end
    @(negedge clk); #1;
    total++; if (v_o_1 !== 1'b0) begin bad++; $display("FAIL d1_empty: got %0d want 0", v_o_1); end
  endtask

  initial begin
    rst = 1'b0; v_i = 1'b0; stall_i = 1'b0; inst_i = '0; origaddr_i = '0;
    rd_data_i = '0; rs_data_i = '0; rd_reserved_i = 1'b0; rs_reserved_i = 1'b0;
    test_reset();
    test_imm_add();
    test_fill();
    test_back_to_back();
    test_hazard();
    test_decode();
    test_reset_mid();
    test_wrap();
    test_depth1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idecode_q.md
IDECODE_Q -- requirements
Module: idecode_q

Interface
REQ-001 Parameters SHALL be: WORD 32 (data/instruction width); ADDR 32 (address width); W_RD 3 (register-name width); DEPTH 2 (output queue entries, power of two, >=1).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  async active-low reset
- v_i  in  1  instruction valid from IF
- inst_i  in  WORD  instruction, fields per the standard instruction-format header
- origaddr_i  in  ADDR  instruction address
- stall_o  out  1  instruction not accepted this cycle
- v_o  out  1  queue head valid
- stall_i  in  1  EX not accepting head
- src_o, dest_o  out  WORD  head operand data
- wb_o  out  1  head requires writeback
- wb_rd_name_o  out  W_RD  head destination name
- dopc_o  out  W_DOPC  head decoded opcode
- opc_o  out  W_OPC  head raw opcode
- cc_o  out  W_CC  head condition code
- origaddr_o  out  ADDR  head address
- count_o  out  clog2(DEPTH+1)  queue occupancy
- rd_reserve_o  out  1  reserve rd in RF
- rd_name_o, rs_name_o  out  W_RD  RF read names, combinational from inst_i
- rd_data_i, rs_data_i  in  WORD  RF read data
- rd_reserved_i, rs_reserved_i  in  1  RF scoreboard busy bits

Function
REQ-004 hazard = rd_reserved_i | (~immf & rs_reserved_i), combinational.
REQ-005 pop = v_o & ~stall_i; full = (count_o == DEPTH).
REQ-006 push = v_i & ~hazard & (~full | pop); a full queue SHALL accept when popping in the same cycle.
REQ-007 stall_o = v_i & ~push.
REQ-008 rd_reserve_o = push & wb_required(opcode); no reservation on non-push cycles.
REQ-009 Entry on push: src = immf ? expand_imm(opcode, imm) : rs_data_i; dest = rd_data_i; dopc = decode_ope(opcode); opc = opcode; cc = low W_CC bits of rd name; wb = wb_required(opcode); wb_rd_name = rd name; origaddr = origaddr_i.
REQ-010 Queue SHALL be FIFO; head outputs SHALL come from registered storage, never combinationally from inst_i.
REQ-011 Latency: an instruction pushed at edge N SHALL appear at head after edge N when the queue was empty.
REQ-012 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count_o SHALL change +1 on push-only, -1 on pop-only, 0 on both or neither.
REQ-013 v_o = (count_o != 0); head fields SHALL hold stable while v_o & stall_i.
REQ-014 Head fields when v_o = 0 are don't-care; v_o alone qualifies them.
REQ-015 Push with v_i = 0 or hazard = 1 SHALL NOT alter queue storage or pointers.
REQ-016 DEPTH = 1 SHALL behave as a single pipeline register with full-throughput pass-through (push & pop same cycle).

Reset
REQ-017 On rst low, asynchronously: pointers 0, count_o 0, v_o 0, all stored entry fields 0.
REQ-018 rd_reserve_o SHALL be 0 while rst is low.
REQ-019 Reset mid-operation SHALL discard all entries; no pop is reported for discarded entries.

Verification
REQ-020 Reset, then v_i=1, immf=1, ADD rd=r2 imm=5, no hazards -> rd_reserve_o=1 in same cycle; next cycle v_o=1, src_o=expand_imm(5), wb_rd_name_o=2, count_o=1.
REQ-021 stall_i=1, three back-to-back pushes, DEPTH=2 -> count_o 1,2,2; stall_o=1 on third; rd_reserve_o=0 on third.
REQ-022 Full queue, stall_i=0, v_i=1 -> push and pop same cycle, count_o stays 2, FIFO order preserved over 8 instructions.
REQ-023 immf=0, rs_reserved_i=1 -> stall_o=1, no push; same instruction with immf=1 -> accepted.
REQ-024 rst low with count_o=2 -> v_o=0, count_o=0 immediately; first push after release appears at head next cycle.
REQ-025 Pointer wrap: 10 push/pop pairs at DEPTH=2 with stall_i toggling -> output order equals input order, origaddr_o matches.
